// File: rtl/fetch_latch.sv
// IF/ID pipeline register built as a two-entry skid buffer (main + skid) so in_ready is registered.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining FETCH_LATCH_PERF_EN.
module fetch_latch #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    next_pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instr_out,
   output logic               out_valid,
   input  logic               out_ready
`ifdef FETCH_LATCH_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             r_state;
   logic [PC_W-1:0]    r_main_pc;
   logic [INSTR_W-1:0] r_main_instr;
   logic [PC_W-1:0]    r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;
   logic               r_in_ready;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_take;

   assign w_accept  = in_valid & r_in_ready;
   assign w_take    = r_out_valid & out_ready;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign pc_out    = r_main_pc;
   assign instr_out = r_main_instr;

   // Main always holds the oldest entry; skid only fills when decode stalls while fetch pushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= EMPTY;
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
      end else if (flush) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_main_pc    <= next_pc;
                  r_main_instr <= instr;
                  r_out_valid  <= 1'b1;
                  r_state      <= ONE;
               end
            end
            ONE: begin
               if (w_accept && w_take) begin
                  r_main_pc    <= next_pc;
                  r_main_instr <= instr;
               end else if (w_accept) begin
                  r_skid_pc    <= next_pc;
                  r_skid_instr <= instr;
                  r_in_ready   <= 1'b0;
                  r_state      <= FULL;
               end else if (w_take) begin
                  r_out_valid  <= 1'b0;
                  r_state      <= EMPTY;
               end
            end
            FULL: begin
               if (w_take) begin
                  r_main_pc    <= r_skid_pc;
                  r_main_instr <= r_skid_instr;
                  r_in_ready   <= 1'b1;
                  r_state      <= ONE;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_LATCH_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (r_out_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush && (r_state != EMPTY) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_latch.sv
// Testbench for fetch_latch: directed scenarios plus randomized traffic checked against a queue model.
module tb_fetch_latch;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 16;

   typedef struct {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] ins;
   } entry_t;

   logic               clk;
   logic               rst_n;
   logic [PC_W-1:0]    next_pc;
   logic [INSTR_W-1:0] instr;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic [PC_W-1:0]    pc_out;
   logic [INSTR_W-1:0] instr_out;
   logic               out_valid;
   logic               out_ready;
`ifdef FETCH_LATCH_PERF_EN
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;
   int                 mStall;
   int                 mFlush;
`endif

   entry_t q[$];
   int     checks;
   int     errors;

   fetch_latch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_pc   (next_pc),
      .instr     (instr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .pc_out    (pc_out),
      .instr_out (instr_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef FETCH_LATCH_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                                input logic ordy, input logic fl);
      in_valid  = v;
      next_pc   = pc;
      instr     = ins;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Queue model: the latch is a FIFO of depth 2; flush empties it, reset empties it.
   task automatic modelReset();
      q.delete();
`ifdef FETCH_LATCH_PERF_EN
      mStall = 0;
      mFlush = 0;
`endif
   endtask

   task automatic modelStep();
      int     sz;
      bit     acc;
      bit     tk;
      entry_t e;
      sz  = q.size();
      acc = in_valid && (sz < 2);
      tk  = (sz > 0) && out_ready;
`ifdef FETCH_LATCH_PERF_EN
      if (sz > 0 && !out_ready && mStall < (2**CNT_W) - 1) mStall++;
      if (flush && sz > 0 && mFlush < (2**CNT_W) - 1) mFlush++;
`endif
      if (flush) begin
         q.delete();
      end else begin
         if (tk) void'(q.pop_front());
         if (acc) begin
            e.pc  = next_pc;
            e.ins = instr;
            q.push_back(e);
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      checkVal("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      if (q.size() > 0) begin
         checkVal("pc_out", {32'd0, pc_out}, {32'd0, q[0].pc});
         checkVal("instr_out", {32'd0, instr_out}, {32'd0, q[0].ins});
      end
`ifdef FETCH_LATCH_PERF_EN
      checkVal("stall_cnt", {48'd0, stall_cnt}, 64'(mStall));
      checkVal("flush_cnt", {48'd0, flush_cnt}, 64'(mFlush));
`endif
   endtask

   task automatic runCycle();
      @(posedge clk);
      if (rst_n) modelStep();
      else modelReset();
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      modelReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      #7;
      checkVal("rst out_valid", {63'd0, out_valid}, 64'd0);
      checkVal("rst pc_out", {32'd0, pc_out}, 64'd0);
      checkVal("rst instr_out", {32'd0, instr_out}, 64'd0);
      checkVal("rst in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single fill
      applyStimulus(1'b1, 32'h100, 32'h8C220004, 1'b1, 1'b0);
      runCycle();
      checkVal("fill out_valid", {63'd0, out_valid}, 64'd1);
      checkVal("fill pc_out", {32'd0, pc_out}, 64'h100);
      checkVal("fill instr_out", {32'd0, instr_out}, 64'h8C220004);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      runCycle();
      checkVal("fill drain", {63'd0, out_valid}, 64'd0);

      // Streaming at one per cycle
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 32'hA000 + 32'(i), 1'b1, 1'b0);
         runCycle();
         checkVal("stream pc_out", {32'd0, pc_out}, 64'(i * 4));
         checkVal("stream in_ready", {63'd0, in_ready}, 64'd1);
      end
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      runCycle();

      // Stall into the skid entry
      applyStimulus(1'b1, 32'h10, 32'h1110, 1'b0, 1'b0);
      runCycle();
      applyStimulus(1'b1, 32'h14, 32'h1114, 1'b0, 1'b0);
      runCycle();
      checkVal("stall in_ready", {63'd0, in_ready}, 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         runCycle();
         checkVal("stall hold pc", {32'd0, pc_out}, 64'h10);
      end
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      runCycle();
      checkVal("skid pc", {32'd0, pc_out}, 64'h14);
      checkVal("skid in_ready", {63'd0, in_ready}, 64'd1);
      runCycle();
      checkVal("skid drain", {63'd0, out_valid}, 64'd0);

      // Flush from FULL discards the offered input as well
      applyStimulus(1'b1, 32'h20, 32'h2220, 1'b0, 1'b0);
      runCycle();
      applyStimulus(1'b1, 32'h24, 32'h2224, 1'b0, 1'b0);
      runCycle();
      applyStimulus(1'b1, 32'h28, 32'h2228, 1'b0, 1'b1);
      runCycle();
      checkVal("flush out_valid", {63'd0, out_valid}, 64'd0);
      checkVal("flush in_ready", {63'd0, in_ready}, 64'd1);
      applyStimulus(1'b1, 32'h40, 32'h2240, 1'b0, 1'b0);
      runCycle();
      checkVal("post flush pc", {32'd0, pc_out}, 64'h40);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      runCycle();
      checkVal("post flush drain", {63'd0, out_valid}, 64'd0);

      // Async reset between edges while FULL
      applyStimulus(1'b1, 32'h50, 32'h3350, 1'b0, 1'b0);
      runCycle();
      applyStimulus(1'b1, 32'h54, 32'h3354, 1'b0, 1'b0);
      runCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("async out_valid", {63'd0, out_valid}, 64'd0);
      checkVal("async pc_out", {32'd0, pc_out}, 64'd0);
      checkVal("async in_ready", {63'd0, in_ready}, 64'd1);
      modelReset();
      runCycle();
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
         runCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_latch.md
Name: fetch_latch

Overview:
- IF/ID pipeline register: captures fetched PC and instruction from the fetch stage and presents them to decode.
- Producer-side counterpart of the ID/EX latch. Unlike that latch, it carries a valid/ready handshake so decode can stall fetch.
- Two-entry skid buffer (main + skid) so in_ready is a registered signal; supports branch flush.

Parameters:
- PC_W, 32, width of program counter
- INSTR_W, 32, width of instruction word
- CNT_W, 16, width of perf counters (optional feature only)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- next_pc  input  PC_W  PC of fetched instruction
- instr  input  INSTR_W  fetched instruction word
- in_valid  input  1  fetch presents next_pc/instr
- in_ready  output  1  latch can accept; registered
- flush  input  1  synchronous discard of all held entries (branch taken)
- pc_out  output  PC_W  PC to decode; registered
- instr_out  output  INSTR_W  instruction to decode; registered
- out_valid  output  1  pc_out/instr_out valid
- out_ready  input  1  decode accepts this cycle; low = stall

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n. Polarity and synchronicity are fixed.
- Reset (rst_n=0, async):
  - State EMPTY.
  - pc_out=0, instr_out=0, out_valid=0, in_ready=1.
  - Skid registers cleared to 0.
  - Reset mid-transfer drops all entries with no output glitch after the reset edge.
- Handshake definitions:
  - accept = in_valid & in_ready
  - take = out_valid & out_ready
  - Outputs change only on clk edges.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, out_valid=1, in_ready=1.
  - FULL: main and skid valid, out_valid=1, in_ready=0.
- Transitions (flush=0):
  - EMPTY, accept: main<=inputs, go to ONE. Latency 1 cycle from accept to out_valid.
  - EMPTY, no accept: stay.
  - ONE, accept & take: main<=inputs, stay ONE. Back-to-back throughput is 1 per cycle.
  - ONE, accept & !take: skid<=inputs, go to FULL, in_ready<=0.
  - ONE, !accept & take: go to EMPTY, out_valid<=0.
  - ONE, neither: hold.
  - FULL, take: main<=skid, go to ONE, in_ready<=1. No accept is possible in FULL since in_ready=0.
  - FULL, !take: hold all outputs stable. Stable-while-stalled is a required property.
- Flush:
  - Highest priority over every other event.
  - Next state EMPTY, out_valid<=0, in_ready<=1.
  - An input offered in the flush cycle is discarded even if in_ready=1.
  - A take in the flush cycle still counts as consumed by decode.
- Data when out_valid=0: pc_out/instr_out hold their last value and are don't-care to decode. The bench must not check them.
- Ordering: entries leave strictly in arrival order. No duplication or loss except by flush.
- in_valid may drop without a transfer; the latch does not require producer persistence.

Optional Feature:
- Macro: FETCH_LATCH_PERF_EN
- Defined:
  - Adds outputs stall_cnt (CNT_W) and flush_cnt (CNT_W), both reset to 0 asynchronously.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while state != EMPTY.
  - Both saturate at all-ones; no wrap.
- Undefined: ports and counter logic absent. Datapath behaviour is identical either way.

Test Plan:
- Reset/fill: rst_n low then high; drive next_pc=0x100, instr=0x8C220004, in_valid=1 for 1 cycle with out_ready=1 -> next cycle out_valid=1, pc_out=0x100, instr_out=0x8C220004; following cycle out_valid=0.
- Streaming: in_valid=1 with PCs 0x0,0x4,0x8,0xC on consecutive cycles, out_ready=1 -> outputs appear 1 cycle later in the same order; in_ready stays 1 throughout.
- Stall/skid: fill with 0x10 then 0x14 while out_ready=0 -> in_ready=0 after the second accept; pc_out holds 0x10 for 3 stalled cycles; out_ready=1 -> 0x10 then 0x14, then in_ready returns to 1.
- Flush: state FULL (0x20, 0x24) with flush=1 and in_valid=1, next_pc=0x28 -> next cycle out_valid=0, in_ready=1; 0x20, 0x24 and 0x28 never appear; the next accept of 0x40 emerges alone.
- Async reset mid-stall: FULL state, rst_n pulled low between edges -> out_valid=0, pc_out=0, in_ready=1 immediately without waiting for clk.
- FETCH_LATCH_PERF_EN defined: 5 stall cycles plus 2 flushes while non-empty -> stall_cnt=5, flush_cnt=2; force CNT_W=2 with 6 stalls -> stall_cnt holds 3.
